pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage rv32imc pipeline.
- Watches decode source operands, the instruction currently in EX, branch resolution and the data-memory handshake.
- Drives per-register hold/bubble controls for PC, IF/ID, ID/EX and EX/MEM, so the ID/EX register captures, holds, or loads a NOP bubble on each cycle.
- Also keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 17 +
 rtl/pipe_hazard_ctrl_if.sv | 36 +++
 rtl/pipe_hazard_ctrl_lu_detect.sv | 16 +
 rtl/pipe_hazard_ctrl.sv | 106 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared FSM state and pipeline-control types for the hazard sequencer
// Provides HazStateType, PipeCtrlType and the canned control patterns used by the sequencer.
package pipe_hazard_ctrl_pkg;
   typedef enum logic [1:0] {HAZ_RUN = 2'd0, HAZ_MEM_WAIT = 2'd1, HAZ_REDIRECT = 2'd2} HazStateType;
   typedef struct packed {
      logic pc_stall;
      logic ifid_stall;
      logic ifid_flush;
      logic idex_stall;
      logic idex_flush;
      logic exmem_stall;
   } PipeCtrlType;
   localparam PipeCtrlType CTL_IDLE   = PipeCtrlType'(6'b000000);
   localparam PipeCtrlType CTL_FREEZE = PipeCtrlType'(6'b110101);
   localparam PipeCtrlType CTL_FLUSH  = PipeCtrlType'(6'b001010);
   localparam PipeCtrlType CTL_LU     = PipeCtrlType'(6'b110010);
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: bundle of decode/EX/memory observations and stall/flush controls
// master: pipeline side driving observations; slave: hazard sequencer driving controls.
interface pipe_hazard_ctrl_if #(parameter int CNT_WIDTH = 32);
   logic                 deValid;
   logic [4:0]           deRs1Addr;
   logic [4:0]           deRs2Addr;
   logic                 deRs1Used;
   logic                 deRs2Used;
   logic [4:0]           exRdAddr;
   logic                 exRdWriteEn;
   logic                 exLoadSignal;
   logic                 branchTaken;
   logic                 dmemReq;
   logic                 dmemReady;
   logic                 pcStall;
   logic                 ifidStall;
   logic                 ifidFlush;
   logic                 idexStall;
   logic                 idexFlush;
   logic                 exmemStall;
   logic                 memTimeout;
   logic [1:0]           hazState;
   logic [CNT_WIDTH-1:0] stallCycles;
   modport master (
      output deValid, deRs1Addr, deRs2Addr, deRs1Used, deRs2Used, exRdAddr, exRdWriteEn,
             exLoadSignal, branchTaken, dmemReq, dmemReady,
      input  pcStall, ifidStall, ifidFlush, idexStall, idexFlush, exmemStall, memTimeout,
             hazState, stallCycles
   );
   modport slave (
      input  deValid, deRs1Addr, deRs2Addr, deRs1Used, deRs2Used, exRdAddr, exRdWriteEn,
             exLoadSignal, branchTaken, dmemReq, dmemReady,
      output pcStall, ifidStall, ifidFlush, idexStall, idexFlush, exmemStall, memTimeout,
             hazState, stallCycles
   );
endinterface

// File: rtl/pipe_hazard_ctrl_lu_detect.sv
// hazard_lu_detect: flags a decode instruction that reads the rd of a load currently in EX
// Ports: decode valid/rs indices/use flags, EX rd/write-enable/load flag in; lu out.
module hazard_lu_detect (
   input  logic       de_valid,
   input  logic [4:0] rs1,
   input  logic [4:0] rs2,
   input  logic       rs1_used,
   input  logic       rs2_used,
   input  logic [4:0] ex_rd,
   input  logic       ex_we,
   input  logic       ex_load,
   output logic       lu
);
   assign lu = de_valid & ex_load & ex_we & (ex_rd != 5'd0) &
               ((rs1_used & (rs1 == ex_rd)) | (rs2_used & (rs2 == ex_rd)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline (memory wait > branch > load-use)
// Ports: clk, rst (sync, active-high); bus (slave) carries observations in and stall/flush,
// timeout pulse, debug state and saturating stall-cycle count out. Controls are Mealy.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REDIRECT_BUBBLES = 1,
   parameter int MEM_TIMEOUT      = 255,
   parameter int CNT_WIDTH        = 32
) (
   input logic              clk,
   input logic              rst,
   pipe_hazard_ctrl_if.slave bus
);
   HazStateType          state, state_nx;
   PipeCtrlType          ctl;
   logic [2:0]           bub_cnt, bub_nx;
   logic [31:0]          wait_cnt, wait_nx;
   logic                 pend, pend_nx, lu, mem_busy, tmo;
   logic [CNT_WIDTH-1:0] stall_cnt;
   localparam HazStateType AFTER_BRANCH = REDIRECT_BUBBLES > 0 ? HAZ_REDIRECT : HAZ_RUN;
   hazard_lu_detect u_lu (
      .de_valid(bus.deValid),
      .rs1     (bus.deRs1Addr),
      .rs2     (bus.deRs2Addr),
      .rs1_used(bus.deRs1Used),
      .rs2_used(bus.deRs2Used),
      .ex_rd   (bus.exRdAddr),
      .ex_we   (bus.exRdWriteEn),
      .ex_load (bus.exLoadSignal),
      .lu      (lu)
   );
   assign mem_busy = bus.dmemReq & ~bus.dmemReady;
   always_comb begin
      ctl      = CTL_IDLE;
      state_nx = state;
      bub_nx   = bub_cnt;
      wait_nx  = '0;
      pend_nx  = pend;
      tmo      = 1'b0;
      if (rst) ctl = CTL_FLUSH;
      else case (state)
         HAZ_RUN:
            if (mem_busy) begin
               ctl      = CTL_FREEZE;
               pend_nx  = bus.branchTaken;
               state_nx = HAZ_MEM_WAIT;
            end else if (bus.branchTaken) begin
               ctl      = CTL_FLUSH;
               bub_nx   = 3'(REDIRECT_BUBBLES);
               state_nx = AFTER_BRANCH;
            end else ctl = lu ? CTL_LU : CTL_IDLE;
         HAZ_MEM_WAIT:
            if (!bus.dmemReady) begin
               ctl     = CTL_FREEZE;
               wait_nx = wait_cnt + 32'd1;
               tmo     = (MEM_TIMEOUT != 0) && (wait_nx == 32'(MEM_TIMEOUT));
            end else if (pend) begin
               // branch resolved while the access was outstanding lands now
               ctl      = CTL_FLUSH;
               pend_nx  = 1'b0;
               bub_nx   = 3'(REDIRECT_BUBBLES);
               state_nx = AFTER_BRANCH;
            end else begin
               ctl      = lu ? CTL_LU : CTL_IDLE;
               state_nx = HAZ_RUN;
            end
         HAZ_REDIRECT:
            if (mem_busy) begin
               // remaining bubbles are dropped; EX holds a flushed slot so no branch is pending
               ctl      = CTL_FREEZE;
               pend_nx  = 1'b0;
               state_nx = HAZ_MEM_WAIT;
            end else begin
               ctl      = CTL_FLUSH;
               bub_nx   = bub_cnt - 3'd1;
               state_nx = bub_cnt == 3'd1 ? HAZ_RUN : HAZ_REDIRECT;
            end
         default: state_nx = HAZ_RUN;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= HAZ_RUN;
         bub_cnt   <= '0;
         wait_cnt  <= '0;
         pend      <= 1'b0;
         stall_cnt <= '0;
      end else begin
         state     <= state_nx;
         bub_cnt   <= bub_nx;
         wait_cnt  <= wait_nx;
         pend      <= pend_nx;
         stall_cnt <= stall_cnt + CNT_WIDTH'(ctl.pc_stall && (stall_cnt != '1));
      end
   end
   assign bus.pcStall     = ctl.pc_stall;
   assign bus.ifidStall   = ctl.ifid_stall;
   assign bus.ifidFlush   = ctl.ifid_flush;
   assign bus.idexStall   = ctl.idex_stall;
   assign bus.idexFlush   = ctl.idex_flush;
   assign bus.exmemStall  = ctl.exmem_stall;
   assign bus.memTimeout  = tmo;
   assign bus.hazState    = state;
   assign bus.stallCycles = stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized checks of pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;
   localparam int RB = 1;
   localparam int MT = 4;
   localparam int CW = 6;
   localparam int CMAX = (1 << CW) - 1;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   pipe_hazard_ctrl_if #(.CNT_WIDTH(CW)) bus ();
   pipe_hazard_ctrl #(.REDIRECT_BUBBLES(RB), .MEM_TIMEOUT(MT), .CNT_WIDTH(CW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   // model: mode 0 = running, 1 = waiting on memory, 2 = redirect bubbles
   int   m_mode = 0, m_left = 0, m_waited = 0, m_cnt = 0;
   bit   m_pend = 0, m_known = 0;
   // last sampled DUT outputs, {pc, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem}
   logic [5:0] s_ctl;
   logic       s_tmo;
   logic [1:0] s_st;
   logic [CW-1:0] s_cnt;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", n, a, e, $time);
      end
   endtask
   function automatic bit lu_m();
      return bus.deValid && bus.exLoadSignal && bus.exRdWriteEn && bus.exRdAddr != 0 &&
             ((bus.deRs1Used && bus.deRs1Addr == bus.exRdAddr) ||
              (bus.deRs2Used && bus.deRs2Addr == bus.exRdAddr));
   endfunction
   task automatic idle_in();
      bus.deValid = 0; bus.deRs1Addr = 0; bus.deRs2Addr = 0; bus.deRs1Used = 0; bus.deRs2Used = 0;
      bus.exRdAddr = 0; bus.exRdWriteEn = 0; bus.exLoadSignal = 0; bus.branchTaken = 0;
      bus.dmemReq = 0; bus.dmemReady = 0;
   endtask
   // one clock: compare at negedge against the model, advance the model at posedge
   task automatic cycle();
      logic [5:0] e;
      bit et, np, busy;
      int nm, nl, nw, nc;
      @(negedge clk);
      busy = bus.dmemReq && !bus.dmemReady;
      e = 6'b000000; et = 0; nm = m_mode; nl = m_left; nw = 0; np = m_pend;
      if (rst) begin
         e = 6'b001010; nm = 0; nl = 0; np = 0;
      end else if (m_mode == 1) begin
         if (!bus.dmemReady) begin
            e = 6'b110101; nw = m_waited + 1; et = (MT != 0 && nw == MT);
         end else if (m_pend) begin
            e = 6'b001010; np = 0; nl = RB; nm = RB > 0 ? 2 : 0;
         end else begin
            e = lu_m() ? 6'b110010 : 6'b000000; nm = 0;
         end
      end else if (busy) begin
         e = 6'b110101; np = (m_mode == 0) && bus.branchTaken; nm = 1;
      end else if (m_mode == 2) begin
         e = 6'b001010; nl = m_left - 1; nm = nl == 0 ? 0 : 2;
      end else if (bus.branchTaken) begin
         e = 6'b001010; nl = RB; nm = RB > 0 ? 2 : 0;
      end else if (lu_m()) e = 6'b110010;
      nc = rst ? 0 : (e[5] && m_cnt < CMAX ? m_cnt + 1 : m_cnt);
      s_ctl = {bus.pcStall, bus.ifidStall, bus.ifidFlush, bus.idexStall, bus.idexFlush, bus.exmemStall};
      s_tmo = bus.memTimeout; s_st = bus.hazState; s_cnt = bus.stallCycles;
      chk("pcStall", 32'(s_ctl[5]), 32'(e[5]));
      chk("ifidStall", 32'(s_ctl[4]), 32'(e[4]));
      chk("ifidFlush", 32'(s_ctl[3]), 32'(e[3]));
      chk("idexStall", 32'(s_ctl[2]), 32'(e[2]));
      chk("idexFlush", 32'(s_ctl[1]), 32'(e[1]));
      chk("exmemStall", 32'(s_ctl[0]), 32'(e[0]));
      chk("memTimeout", 32'(s_tmo), 32'(et));
      if (m_known) begin
         chk("hazState", 32'(s_st), 32'(m_mode));
         chk("stallCycles", 32'(s_cnt), 32'(m_cnt));
      end
      @(posedge clk);
      if (rst) m_known = 1;
      m_mode = nm; m_left = nl; m_waited = nw; m_pend = np; m_cnt = nc;
      #1;
   endtask
   initial begin
      idle_in();
      rst = 1;
      cycle();
      chk("rst_flush", 32'({s_ctl[3], s_ctl[1], s_ctl[5]}), 32'b110);
      cycle();
      rst = 0;
      // load-use: lw x5 in EX, add x6,x5,x1 in decode
      bus.exRdAddr = 5; bus.exRdWriteEn = 1; bus.exLoadSignal = 1;
      bus.deValid = 1; bus.deRs1Addr = 5; bus.deRs2Addr = 1; bus.deRs1Used = 1; bus.deRs2Used = 1;
      cycle();
      chk("lu_ctl", 32'(s_ctl), 32'b110010);
      bus.exRdAddr = 0; bus.deRs1Addr = 0;
      cycle();
      chk("lu_x0", 32'(s_ctl), 32'b000000);
      idle_in();
      // taken branch with one extra bubble
      bus.branchTaken = 1;
      cycle();
      chk("br_resolve", 32'({s_st, s_ctl}), 32'({2'd0, 6'b001010}));
      bus.branchTaken = 0;
      cycle();
      chk("br_bubble", 32'({s_st, s_ctl}), 32'({2'd2, 6'b001010}));
      cycle();
      chk("br_done", 32'({s_st, s_ctl}), 32'({2'd0, 6'b000000}));
      // memory wait: four freeze cycles
      bus.dmemReq = 1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("mw_freeze", 32'(s_ctl), 32'b110101);
      end
      bus.dmemReady = 1;
      cycle();
      chk("mw_release", 32'({s_st, s_ctl}), 32'({2'd1, 6'b000000}));
      idle_in();
      cycle();
      chk("mw_count", 32'({s_st, s_cnt}), 32'({2'd0, 6'd5}));
      // branch resolving while memory stalls
      bus.dmemReq = 1; bus.branchTaken = 1;
      cycle();
      chk("bm_freeze0", 32'(s_ctl), 32'b110101);
      bus.branchTaken = 0;
      cycle();
      cycle();
      chk("bm_freeze2", 32'(s_ctl), 32'b110101);
      bus.dmemReady = 1;
      cycle();
      chk("bm_flush", 32'(s_ctl), 32'b001010);
      idle_in();
      cycle();
      chk("bm_bubble", 32'({s_st, s_ctl}), 32'({2'd2, 6'b001010}));
      cycle();
      chk("bm_done", 32'({s_st, s_ctl}), 32'({2'd0, 6'b000000}));
      // timeout after four waiting cycles
      bus.dmemReq = 1;
      cycle();
      for (int k = 1; k <= 6; k++) begin
         cycle();
         chk("to_pulse", 32'({s_tmo, s_ctl[5]}), 32'({k == 4, 1'b1}));
      end
      bus.dmemReady = 1;
      cycle();
      idle_in();
      cycle();
      // reset during redirect
      bus.branchTaken = 1;
      cycle();
      bus.branchTaken = 0; rst = 1;
      cycle();
      chk("rst_redir", 32'({s_st, s_ctl}), 32'({2'd2, 6'b001010}));
      rst = 0;
      cycle();
      chk("rst_redir_after", 32'({s_st, s_cnt, s_ctl}), 32'({2'd0, 6'd0, 6'b000000}));
      // reset during memory wait
      bus.dmemReq = 1;
      cycle();
      cycle();
      rst = 1;
      cycle();
      chk("rst_mw", 32'({s_st, s_ctl}), 32'({2'd1, 6'b001010}));
      rst = 0; idle_in();
      cycle();
      chk("rst_mw_after", 32'({s_st, s_cnt, s_ctl}), 32'({2'd0, 6'd0, 6'b000000}));
      // randomized traffic
      for (int n = 0; n < 4000; n++) begin
         bus.deValid = $urandom_range(0, 3) != 0;
         bus.deRs1Addr = 5'($urandom_range(0, 3));
         bus.deRs2Addr = 5'($urandom_range(0, 3));
         bus.deRs1Used = 1'($urandom);
         bus.deRs2Used = 1'($urandom);
         bus.exRdAddr = 5'($urandom_range(0, 3));
         bus.exRdWriteEn = $urandom_range(0, 3) != 0;
         bus.exLoadSignal = 1'($urandom);
         bus.branchTaken = $urandom_range(0, 6) == 0;
         bus.dmemReq = $urandom_range(0, 2) == 0;
         bus.dmemReady = $urandom_range(0, 2) == 0;
         rst = $urandom_range(0, 150) == 0;
         cycle();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
